// File: rtl/us_ranging_sched.sv
// Round-robin scheduler for N_SENS ultrasonic ranging channels: one start pulse per shot,
// watchdog on each shot, idle gap between shots, and a sticky merged pedestrian request.
module us_ranging_sched #(
  parameter int N_SENS  = 2,
  parameter int CLK_HZ  = 50_000_000,
  parameter int GAP_MS  = 60,
  parameter int WDOG_MS = 40,
  localparam int IW     = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [N_SENS-1:0] start_o,
  input  logic [N_SENS-1:0] busy_i,
  input  logic [N_SENS-1:0] done_i,
  input  logic [N_SENS-1:0] ped_req_i,
  input  logic              ped_clr,
  input  logic              flt_clr,
  output logic              ped_latched,
  output logic [N_SENS-1:0] ped_src,
  output logic [N_SENS-1:0] fault,
  output logic [IW-1:0]     cur_idx,
  output logic              round_pulse
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW       = $clog2(WDOG_MS + 1);
  localparam int GW       = $clog2(GAP_MS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic              ms_tick;
  logic [WW-1:0]     wdog;
  logic [GW-1:0]     gap;
  logic              wdog_zero, gap_zero;
  logic              busy_cur, done_cur;
  logic              load_wdog, load_gap, advance, wrap;
  logic [N_SENS-1:0] fault_set;
  logic [N_SENS-1:0] ped_src_nxt;

  function automatic logic [WW-1:0] wdog_dec(input logic [WW-1:0] v);
    return (v == '0) ? '0 : v - WW'(1);
  endfunction

  function automatic logic [GW-1:0] gap_dec(input logic [GW-1:0] v);
    return (v == '0) ? '0 : v - GW'(1);
  endfunction

  assign ms_tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign wdog_zero = (wdog == '0);
  assign gap_zero  = (gap == '0);
  assign busy_cur  = busy_i[cur_idx];
  assign done_cur  = done_i[cur_idx];
  assign wrap      = (cur_idx == IW'(N_SENS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (ms_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a done arriving with the watchdog expiry takes the clean path
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!busy_cur) begin
          state_nxt = S_WAIT;
        end else if (wdog_zero) begin
          state_nxt = S_GAP;
        end
      end
      S_WAIT:  if (done_cur || wdog_zero) state_nxt = S_GAP;
      S_GAP:   if (gap_zero) state_nxt = en ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_o   = '0;
    fault_set = '0;
    advance   = 1'b0;
    case (state)
      S_ISSUE: begin
        if (!busy_cur) begin
          start_o[cur_idx] = 1'b1;
        end else if (wdog_zero) begin
          fault_set[cur_idx] = 1'b1;
        end
      end
      S_WAIT: begin
        if (!done_cur && wdog_zero) fault_set[cur_idx] = 1'b1;
      end
      S_GAP:   advance = gap_zero;
      default: advance = 1'b0;
    endcase
  end

  assign load_wdog = (state_nxt == S_ISSUE) && (state != S_ISSUE);
  assign load_gap  = (state_nxt == S_GAP) && (state != S_GAP);

  // Loads take priority over a coincident tick so every shot gets its full budget
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
      gap  <= '0;
    end else begin
      if (load_wdog) begin
        wdog <= WW'(WDOG_MS);
      end else if (ms_tick) begin
        wdog <= wdog_dec(wdog);
      end
      if (load_gap) begin
        gap <= GW'(GAP_MS);
      end else if (ms_tick) begin
        gap <= gap_dec(gap);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx     <= '0;
      round_pulse <= 1'b0;
    end else begin
      round_pulse <= advance && wrap;
      if (advance) begin
        cur_idx <= wrap ? '0 : cur_idx + IW'(1);
      end
    end
  end

  // New requests and new faults are OR-ed in after the clear so they are never lost
  assign ped_src_nxt = (ped_clr ? '0 : ped_src) | ped_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_src     <= '0;
      ped_latched <= 1'b0;
      fault       <= '0;
    end else begin
      ped_src     <= ped_src_nxt;
      ped_latched <= |ped_src_nxt;
      fault       <= (flt_clr ? '0 : fault) | fault_set;
    end
  end

endmodule
